// File: rtl/udp_speed_ctrl.sv
// rtl/udp_speed_ctrl.sv - tri-speed UDP clock-select sequencer with debounce, drain, quiesce and settle phases
module udp_speed_ctrl #(
    parameter logic [15:0] DEBOUNCE_CYC  = 16'd1250,
    parameter logic [15:0] DRAIN_TIMEOUT = 16'd50000,
    parameter logic [15:0] QUIESCE_CYC   = 16'd64,
    parameter logic [15:0] SETTLE_CYC    = 16'd256
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       phy_link_up,
    input  logic [1:0] phy_speed,
    input  logic       speed_override_en,
    input  logic [1:0] speed_override,
    input  logic       tx_busy,
    output logic [1:0] tri_speed,
    output logic       udp_rst_n,
    output logic       drain_req,
    output logic       speed_valid,
    output logic       switch_busy
);

    typedef enum logic [2:0] {
        DOWN, DEB, DRAIN, HOLD, SWITCH, SETTLE, RUN
    } state_t;

    localparam logic [1:0] SPEED_1000 = 2'b10;
    localparam logic [1:0] SPEED_BAD  = 2'b11;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        lat_link_q, lat_link_d;
    logic [1:0]  lat_tgt_q, lat_tgt_d;
    logic [1:0]  tri_speed_q, tri_speed_d;
    logic        udp_rst_n_q, udp_rst_n_d;

    logic [1:0]  target;
    logic        target_ok;
    logic        restart;
    logic [15:0] cnt_sat;
    logic [16:0] cnt_plus1;
    logic        deb_done, drain_done, quiesce_done, settle_done;
    logic        lat_bad;

    always_comb begin
        target       = speed_override_en ? speed_override : phy_speed;
        target_ok    = (target != SPEED_BAD);
        lat_bad      = (lat_tgt_q == SPEED_BAD);
        cnt_sat      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        // "+1" so a phase lasts exactly N cycles counting its entry cycle
        cnt_plus1    = {1'b0, cnt_q} + 17'd1;
        deb_done     = (cnt_plus1 >= {1'b0, DEBOUNCE_CYC});
        drain_done   = (cnt_plus1 >= {1'b0, DRAIN_TIMEOUT});
        quiesce_done = (cnt_plus1 >= {1'b0, QUIESCE_CYC});
        settle_done  = (cnt_plus1 >= {1'b0, SETTLE_CYC});
    end

    always_comb begin
        state_d    = state_q;
        lat_link_d = lat_link_q;
        lat_tgt_d  = lat_tgt_q;
        restart    = 1'b0;
        case (state_q)
            DOWN: begin
                if (phy_link_up && target_ok) begin
                    state_d    = DEB;
                    lat_link_d = 1'b1;
                    lat_tgt_d  = target;
                end
            end
            DEB: begin
                if (!phy_link_up && !udp_rst_n_q) begin
                    state_d = DOWN;
                end else if ({phy_link_up, target} != {lat_link_q, lat_tgt_q}) begin
                    lat_link_d = phy_link_up;
                    lat_tgt_d  = target;
                    restart    = 1'b1;
                end else if (deb_done) begin
                    // A settled invalid target never reaches the clock mux
                    if (udp_rst_n_q && lat_link_q && (lat_bad || lat_tgt_q == tri_speed_q))
                        state_d = RUN;
                    else if (udp_rst_n_q)
                        state_d = DRAIN;
                    else if (lat_bad)
                        state_d = DOWN;
                    else
                        state_d = HOLD;
                end
            end
            RUN: begin
                if (!phy_link_up) begin
                    state_d = DRAIN;
                end else if (target_ok && target != tri_speed_q) begin
                    state_d    = DEB;
                    lat_link_d = 1'b1;
                    lat_tgt_d  = target;
                end
            end
            DRAIN: begin
                if (!tx_busy || drain_done)
                    state_d = HOLD;
            end
            HOLD: begin
                if (quiesce_done)
                    state_d = phy_link_up ? SWITCH : DOWN;
            end
            SWITCH: state_d = SETTLE;
            SETTLE: begin
                if (settle_done)
                    state_d = RUN;
            end
            default: state_d = DOWN;
        endcase
    end

    always_comb begin
        cnt_d       = (state_d != state_q || restart) ? 16'd0 : cnt_sat;
        // Mux select moves on SWITCH entry, while HOLD already has the datapath in reset
        tri_speed_d = (state_d == SWITCH) ? lat_tgt_q : tri_speed_q;
        case (state_d)
            RUN:        udp_rst_n_d = 1'b1;
            DEB, DRAIN: udp_rst_n_d = udp_rst_n_q;
            default:    udp_rst_n_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= DOWN;
            cnt_q       <= 16'd0;
            lat_link_q  <= 1'b0;
            lat_tgt_q   <= SPEED_1000;
            tri_speed_q <= SPEED_1000;
            udp_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_link_q  <= lat_link_d;
            lat_tgt_q   <= lat_tgt_d;
            tri_speed_q <= tri_speed_d;
            udp_rst_n_q <= udp_rst_n_d;
        end
    end

    assign tri_speed   = tri_speed_q;
    assign udp_rst_n   = udp_rst_n_q;
    assign drain_req   = (state_q == DRAIN);
    assign speed_valid = (state_q == RUN);
    assign switch_busy = (state_q == DRAIN) || (state_q == HOLD) ||
                         (state_q == SWITCH) || (state_q == SETTLE);

endmodule

// File: doc/udp_speed_ctrl.md
UDP_SPEED_CTRL -- requirements
Module: udp_speed_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 16'd1250: number of consecutive stable cycles required before a speed or link change is accepted.
REQ-002 Parameter DRAIN_TIMEOUT, default 16'd50000: maximum cycles spent waiting for the TX path to go idle.
REQ-003 Parameter QUIESCE_CYC, default 16'd64: cycles the datapath reset is held before the clock select changes.
REQ-004 Parameter SETTLE_CYC, default 16'd256: cycles the datapath reset is held after the clock select changes.
REQ-005 clk  in  1  free-running 125 MHz control clock, never muxed.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 phy_link_up  in  1  PHY link status, already synchronous to clk.
REQ-008 phy_speed  in  2  PHY speed: 2'b10=1000M, 2'b01=100M, 2'b00=10M, 2'b11=invalid.
REQ-009 speed_override_en  in  1  when 1, speed_override replaces phy_speed.
REQ-010 speed_override  in  2  forced speed, same encoding as phy_speed.
REQ-011 tx_busy  in  1  UDP TX path is mid-frame.
REQ-012 tri_speed  out  2  registered select driving the UDP clock mux.
REQ-013 udp_rst_n  out  1  registered active-low reset for the UDP datapath.
REQ-014 drain_req  out  1  asks the TX path to stop accepting new frames.
REQ-015 speed_valid  out  1  datapath is running at tri_speed.
REQ-016 switch_busy  out  1  a speed transition is in progress.

Function
REQ-017 target SHALL be speed_override when speed_override_en=1, otherwise phy_speed; a target of 2'b11 SHALL be treated as invalid.
REQ-018 The FSM SHALL have exactly these states: DOWN, DEB, DRAIN, HOLD, SWITCH, SETTLE, RUN.
REQ-019 DOWN: udp_rst_n=0. Go to DEB when phy_link_up=1 and target is valid.
REQ-020 DEB:
- Latch {link, target} on entry; any change restarts the count.
- If link=0 and udp_rst_n=0, return to DOWN.
- After DEBOUNCE_CYC stable cycles:
  - target==tri_speed and udp_rst_n=1 → RUN with no reset pulse;
  - udp_rst_n=1 → DRAIN;
  - otherwise → HOLD.
REQ-021 DEB SHALL keep the udp_rst_n value it had on entry; a running datapath is not disturbed while debouncing.
REQ-022 RUN: udp_rst_n=1, speed_valid=1. phy_link_up=0 goes directly to DRAIN. A valid target different from tri_speed goes to DEB. An invalid target is ignored.
REQ-023 DRAIN: drain_req=1. Go to HOLD on the first cycle tx_busy=0, or after DRAIN_TIMEOUT cycles regardless of tx_busy.
REQ-024 HOLD: udp_rst_n=0 from the first HOLD cycle, drain_req=0. After QUIESCE_CYC cycles:
- link=0 → DOWN;
- otherwise → SWITCH.
REQ-025 SWITCH lasts one cycle: tri_speed ← the debounced target.
REQ-026 SETTLE: udp_rst_n=0. After SETTLE_CYC cycles → RUN; udp_rst_n rises on the RUN entry cycle.
REQ-027 switch_busy SHALL be 1 in DRAIN, HOLD, SWITCH and SETTLE, and 0 in all other states.
REQ-028 tri_speed SHALL change only in SWITCH, and only while udp_rst_n=0.
REQ-029 A target change during DRAIN, HOLD or SETTLE SHALL NOT abort the sequence; it is picked up via DEB after RUN is reached.
REQ-030 A link drop during SETTLE SHALL complete SETTLE; RUN then exits on the next cycle.
REQ-031 All counters SHALL be 16 bits, saturating, and cleared on every state entry.

Reset
REQ-032 While reset_n=0, outputs SHALL be tri_speed=2'b10, udp_rst_n=0, drain_req=0, speed_valid=0, switch_busy=0, state=DOWN.
REQ-033 Outputs SHALL take their reset values asynchronously when reset_n falls, including mid-transition.
REQ-034 Release of reset_n SHALL take effect on the first clk edge after deassertion.

Verification
REQ-035 Link up, phy_speed=2'b10 held → RUN at 1+DEBOUNCE_CYC+QUIESCE_CYC+1+SETTLE_CYC cycles; tri_speed=2'b10; udp_rst_n=1.
REQ-036 In RUN, phy_speed toggles 2'b01 for 5 cycles then back to 2'b10 → no DRAIN, udp_rst_n stays 1, tri_speed unchanged.
REQ-037 In RUN, phy_speed→2'b01 stable with tx_busy=1 for 100 cycles → drain_req=1 for those 100 cycles, then HOLD, tri_speed=2'b01 in SWITCH, speed_valid=1 after SETTLE.
REQ-038 tx_busy stuck at 1 → DRAIN exits after exactly DRAIN_TIMEOUT cycles.
REQ-039 Link drop in RUN → DRAIN → HOLD → DOWN, udp_rst_n=0, tri_speed retained.
REQ-040 reset_n pulsed low during SETTLE with tri_speed=2'b00 → immediate tri_speed=2'b10, udp_rst_n=0, state DOWN.
